freq_div_prog: RTL and testbench
================================

# freq_div_prog

Runtime-programmable integer clock divider. It produces a divided clock-enable waveform `out_clk` and a one-cycle `tick` per output period. This generalises the fixed divide-by-2(N+1) divider in three ways:
- any divisor from 2 to 2^W−1, odd or even, with near-50% duty;
- an enable input;
- a valid/ready configuration port whose divisor changes take effect only at period boundaries, so `out_clk` never glitches.

It sits beside the clock-generation logic and feeds baud/strobe timing in the `clk` domain.

## Interface
Parameters:
- `W` = 8. Divisor width.
- `DEFAULT_DIV` = 8. Active divisor after reset. Must satisfy 2 ≤ DEFAULT_DIV ≤ 2^W−1.

Ports:
- `clk`  in  1. Single clock; all logic is rising-edge.
- `rst_n`  in  1. Asynchronous, active-low reset.
- `en`  in  1. Run enable.
- `cfg_valid`  in  1. Divisor update request.
- `cfg_div`  in  W. Requested divisor.
- `cfg_ready`  out  1. Update can be accepted this cycle.
- `out_clk`  out  1. Divided waveform, registered.
- `tick`  out  1. One-cycle pulse at the start of each output period, registered.
- `cfg_err`  out  1. Sticky flag: an illegal divisor was offered.

## Operation
- Internal state:
  - `div_a`: active divisor.
  - `div_s`: shadow divisor.
  - `pend`: shadow holds an update.
  - `run`: divider is running.
  - `p`: phase counter, 0..div_a−1.
  - `hi = (div_a+1)>>1`: number of high cycles per period (ceil(div_a/2)).
- Reset values: `div_a`=DEFAULT_DIV, `div_s`=0, `pend`=0, `run`=0, `p`=0, `out_clk`=0, `tick`=0, `cfg_err`=0, `cfg_ready`=1.
- States:
  - IDLE (`run`=0):
    - `en`=1 at an edge → RUN: `p`←0, `out_clk`←1, `tick`←1.
  - RUN:
    - `p` increments each edge; `p`==div_a−1 wraps to 0. The wrap is the period boundary.
    - `out_clk`←(p_next < hi).
    - `tick`←(p_next==0).
    - `en`=0 at any edge → IDLE immediately: `p`←0, `out_clk`←0, `tick`←0. There is no period completion on stop.
- Configuration handshake:
  - `cfg_ready` = ~pend.
  - Accept = `cfg_valid` & `cfg_ready`.
  - Accept with `cfg_div` < 2: value is discarded and `cfg_err`←1. `cfg_err` stays set until reset.
  - Accept in IDLE (and not starting this edge): `div_a`←cfg_div directly; `pend` stays 0.
  - Accept in RUN, or on the IDLE→RUN edge: `div_s`←cfg_div, `pend`←1.
  - At a period boundary with `pend`=1: `div_a`←div_s, `pend`←0. The new period uses the new divisor from p=0.
- Boundary conditions:
  - Accept on the same edge as a boundary (`pend` was 0): the value goes to the shadow and applies at the next boundary, not the current one.
  - `en` drops while `pend`=1: the shadow loads into `div_a` on the stop edge. The restart then uses the new divisor.
  - Divisor 2^W−1: `p` reaches 2^W−2 without overflow.
  - Divisor 2: `out_clk` alternates 1,0; `tick` fires every other cycle.
  - Asynchronous reset mid-period: all state returns to reset values at once. A pending update is lost.

## Timing
- `out_clk` and `tick` change only on rising `clk`.
- Latency from `en` sampled high to `out_clk`=1 and `tick`=1 is one edge. Same one-edge latency from `en` sampled low to `out_clk`=0.
- Period is exactly div_a cycles:
  - `out_clk` high for ceil(div_a/2) cycles, low for floor(div_a/2) cycles.
  - For odd div_a, the high phase is one cycle longer.
- `cfg_ready` is combinational from `pend` only, with no path from `cfg_valid`. It falls the cycle after a RUN-state accept. It rises the cycle after the boundary load.
- `cfg_err` is set the edge after the illegal accept.

## Structure
- Package `freq_div_pkg`:
  - constant `MIN_DIV` = 2;
  - function computing `hi` from a divisor;
  - IDLE/RUN state enum.
- Sub-module `freq_div_core`: phase counter, `hi` compare, `out_clk`/`tick` registers, `run` state. Inputs are `en` and `div_a`; it exports a boundary strobe.
- The top level holds the shadow register, the handshake and `cfg_err`.

## Test plan
- Reset, DEFAULT_DIV=8, `en`=1 held → `out_clk` 4 high / 4 low repeating; `tick` every 8 cycles, coincident with `out_clk` rising.
- IDLE, accept `cfg_div`=5, then `en`=1 → 3 high / 2 low; `tick` period 5; `cfg_ready` stays 1.
- Running at div 8, accept 3 at p=2 → `cfg_ready`=0 until the boundary. The current period completes at 8 cycles, then 2 high / 1 low. Also accept exactly on a boundary edge → change appears one full period later.
- Offer `cfg_div`=1, then 0 → `cfg_err`=1 and sticky; `div_a` unchanged; waveform unaffected.
- `en` drops at p=5 of a div-8 period → `out_clk`=0, `tick`=0 next edge. Re-enable → fresh period starting at p=0 with `tick`.
- Assert `rst_n` low mid-period with `pend`=1 → all outputs 0, `cfg_ready`=1 immediately. After release, `div_a`=DEFAULT_DIV.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants, state type and helpers for the programmable divider.
// Imported by the divider core and by the top level.
package freq_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // High cycles per period: ceil(d/2)
    function automatic int unsigned hi_of(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/freq_div_core.sv
// Phase counter and registered out_clk/tick generation.
// Exports a strobe on the edge that ends a period or stops the divider.
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div_a,
    output logic         out_clk,
    output logic         tick,
    output logic         run,
    output logic         prd_end
);

    state_e       state_q, state_d;
    logic [W-1:0] p_q, p_d;
    logic         out_q, out_d;
    logic         tick_q, tick_d;
    logic [W-1:0] hi;
    logic         wrap;

    assign hi      = W'(hi_of(32'(div_a)));
    assign wrap    = (p_q == div_a - W'(1));
    assign run     = (state_q == RUN);
    assign prd_end = run & (~en | wrap);
    assign out_clk = out_q;
    assign tick    = tick_q;

    always_comb begin
        state_d = state_q;
        p_d     = '0;
        out_d   = 1'b0;
        tick_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    out_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    p_d    = wrap ? '0 : p_q + W'(1);
                    out_d  = (p_d < hi);
                    tick_d = (p_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

endmodule

// File: rtl/freq_div_prog.sv
// Runtime-programmable clock divider: shadowed divisor, valid/ready
// configuration port and sticky illegal-divisor flag.
module freq_div_prog
    import freq_div_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         out_clk,
    output logic         tick,
    output logic         cfg_err
);

    localparam logic [W-1:0] MIN_W = W'(MIN_DIV);
    localparam logic [W-1:0] DEF_W = W'(DEFAULT_DIV);

    logic [W-1:0] div_a_q, div_a_d;
    logic [W-1:0] div_s_q, div_s_d;
    logic         pend_q, pend_d;
    logic         err_q, err_d;
    logic         run;
    logic         prd_end;
    logic         acc;
    logic         legal;

    assign cfg_ready = ~pend_q;
    assign cfg_err   = err_q;
    assign acc       = cfg_valid & ~pend_q;
    assign legal     = (cfg_div >= MIN_W);

    freq_div_core #(.W(W)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_a   (div_a_q),
        .out_clk (out_clk),
        .tick    (tick),
        .run     (run),
        .prd_end (prd_end)
    );

    always_comb begin
        div_a_d = div_a_q;
        div_s_d = div_s_q;
        pend_d  = pend_q;
        err_d   = err_q;
        if (pend_q && prd_end) begin
            div_a_d = div_s_q;
            pend_d  = 1'b0;
        end
        if (acc && !legal) begin
            err_d = 1'b1;
        end
        // Direct load only while idle and staying idle
        if (acc && legal) begin
            if (!run && !en) begin
                div_a_d = cfg_div;
            end else begin
                div_s_d = cfg_div;
                pend_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a_q <= DEF_W;
            div_s_q <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            div_a_q <= div_a_d;
            div_s_q <= div_s_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// Randomised and directed bench for freq_div_prog against a cycle model.
module tb_freq_div_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic       out_clk;
    logic       tick;
    logic       cfg_err;

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    freq_div_prog #(.W(8), .DEFAULT_DIV(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .out_clk   (out_clk),
        .tick      (tick),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // Model: cycles elapsed in current period, active/shadow divisors
    int   m_div = 8;
    int   m_sh = 0;
    bit   m_pend = 0;
    bit   m_run = 0;
    int   m_k = 0;
    bit   m_err = 0;
    bit   e_out = 0;
    bit   e_tick = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div = 8; m_sh = 0; m_pend = 0; m_run = 0;
            m_k = 0; m_err = 0; e_out = 0; e_tick = 0;
        end else begin
            bit was_run;
            bit acc;
            was_run = m_run;
            acc = cfg_valid && !m_pend;
            if (!m_run) begin
                if (en) begin
                    m_run = 1; m_k = 0;
                end
            end else if (!en) begin
                m_run = 0; m_k = 0;
                if (m_pend) begin m_div = m_sh; m_pend = 0; end
            end else begin
                m_k = m_k + 1;
                if (m_k == m_div) begin
                    m_k = 0;
                    if (m_pend) begin m_div = m_sh; m_pend = 0; end
                end
            end
            if (acc) begin
                if (cfg_div < 2) m_err = 1;
                else if (!was_run && !en) m_div = int'(cfg_div);
                else begin m_sh = int'(cfg_div); m_pend = 1; end
            end
            e_out  = m_run && (m_k < (m_div + 1) / 2);
            e_tick = m_run && (m_k == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("m_out", 32'(out_clk), 32'(e_out));
            chk("m_tick", 32'(tick), 32'(e_tick));
            chk("m_ready", 32'(cfg_ready), 32'(!m_pend));
            chk("m_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic cap(input int n, output logic [31:0] ob,
                       output logic [31:0] tb_);
        ob = '0;
        tb_ = '0;
        repeat (n) begin
            @(negedge clk);
            ob = {ob[30:0], out_clk};
            tb_ = {tb_[30:0], tick};
            cfg_valid = 1'b0;
        end
    endtask

    task automatic offer(input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_div = d;
    endtask

    initial begin
        logic [31:0] ob, tb_;
        int hcnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("rst_out", 32'(out_clk), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_err", 32'(cfg_err), 32'd0);

        // Default divisor 8
        en = 1'b1;
        cap(16, ob, tb_);
        chk("div8_out", ob, 32'b1111000011110000);
        chk("div8_tick", tb_, 32'b1000000010000000);

        // Idle load of 5
        en = 1'b0;
        cap(1, ob, tb_);
        offer(8'd5);
        cap(1, ob, tb_);
        chk("idle_ready", 32'(cfg_ready), 32'd1);
        en = 1'b1;
        cap(10, ob, tb_);
        chk("div5_out", ob, 32'b1110011100);
        chk("div5_tick", tb_, 32'b1000010000);

        // Running at 8, accept 3 at p=2
        en = 1'b0;
        cap(1, ob, tb_);
        offer(8'd8);
        cap(1, ob, tb_);
        en = 1'b1;
        cap(3, ob, tb_);
        offer(8'd3);
        cap(1, ob, tb_);
        chk("pend_ready", 32'(cfg_ready), 32'd0);
        cap(10, ob, tb_);
        chk("sw3_out", ob, 32'b0000110110);
        chk("sw3_tick", tb_, 32'b0000100100);
        chk("sw3_ready", 32'(cfg_ready), 32'd1);

        // Accept on a boundary edge: applies one period later
        offer(8'd4);
        cap(7, ob, tb_);
        chk("bnd_out", ob, 32'b1101100);
        chk("bnd_tick", tb_, 32'b1001000);

        // Illegal divisors
        offer(8'd1);
        cap(1, ob, tb_);
        chk("err_set", 32'(cfg_err), 32'd1);
        offer(8'd0);
        cap(4, ob, tb_);
        chk("err_sticky", 32'(cfg_err), 32'd1);
        chk("err_wave", ob, 32'b1001);

        // Stop at p=5 and restart
        en = 1'b0;
        cap(1, ob, tb_);
        offer(8'd8);
        cap(1, ob, tb_);
        en = 1'b1;
        cap(6, ob, tb_);
        chk("pre_stop_out", ob, 32'b111100);
        en = 1'b0;
        cap(1, ob, tb_);
        chk("stop_out", 32'(out_clk), 32'd0);
        chk("stop_tick", 32'(tick), 32'd0);
        en = 1'b1;
        cap(2, ob, tb_);
        chk("restart_out", ob, 32'b11);
        chk("restart_tick", tb_, 32'b10);

        // Stop while pending loads the shadow
        offer(8'd3);
        cap(1, ob, tb_);
        chk("pend2_ready", 32'(cfg_ready), 32'd0);
        en = 1'b0;
        cap(1, ob, tb_);
        chk("stopload_ready", 32'(cfg_ready), 32'd1);
        en = 1'b1;
        cap(4, ob, tb_);
        chk("stopload_out", ob, 32'b1101);

        // Async reset with an update pending
        offer(8'd5);
        cap(1, ob, tb_);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out_clk), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd1);
        chk("arst_err", 32'(cfg_err), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cap(1, ob, tb_);
        en = 1'b1;
        cap(8, ob, tb_);
        chk("arst_div8", ob, 32'b11110000);

        // Divisor 2
        en = 1'b0;
        cap(1, ob, tb_);
        offer(8'd2);
        cap(1, ob, tb_);
        en = 1'b1;
        cap(4, ob, tb_);
        chk("div2_out", ob, 32'b1010);
        chk("div2_tick", tb_, 32'b1010);

        // Divisor 255
        en = 1'b0;
        cap(1, ob, tb_);
        offer(8'd255);
        cap(1, ob, tb_);
        en = 1'b1;
        hcnt = 0;
        for (int i = 0; i < 255; i++) begin
            cap(1, ob, tb_);
            hcnt += int'(ob[0]);
        end
        chk("div255_high", 32'(hcnt), 32'd128);
        cap(1, ob, tb_);
        chk("div255_wrap", tb_, 32'd1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 29) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) cfg_div = 8'($urandom_range(0, 255));
            else cfg_div = 8'($urandom_range(0, 12));
            if (i == 2500) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
